// File: rtl/dps_uart_rx_pkg.sv
// Shared UART definitions: baud codes, the 50 MHz divisor table and receiver FSM states.
package dps_uart_rx_pkg;

   localparam int DIV_W = 9;

   localparam logic [3:0] BAUD_9600   = 4'd0;
   localparam logic [3:0] BAUD_19200  = 4'd1;
   localparam logic [3:0] BAUD_38400  = 4'd2;
   localparam logic [3:0] BAUD_57600  = 4'd3;
   localparam logic [3:0] BAUD_115200 = 4'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3,
      ST_WAITHI = 3'd4
   } rx_state_e;

   // 16x oversampling prescale divisor; unused codes fall back to 9600 baud
   function automatic logic [DIV_W-1:0] baud_div(input logic [3:0] code);
      case (code)
         BAUD_9600:   return 9'd326;
         BAUD_19200:  return 9'd163;
         BAUD_38400:  return 9'd81;
         BAUD_57600:  return 9'd54;
         BAUD_115200: return 9'd27;
         default:     return 9'd326;
      endcase
   endfunction

endpackage

// File: rtl/dps_uart_rx_fifo.sv
// Receive byte FIFO: 2**AW slots, one kept free so the count fits AW bits.
// Clear wins over push and pop; status and event pulses are registered together.
module dps_uart_rx_fifo #(
   parameter int AW = 4
) (
   input  logic          iIF_CLOCK,
   input  logic          inRESET,
   input  logic          clear_i,
   input  logic          push_i,
   input  logic [7:0]    data_i,
   input  logic          pop_i,
   output logic [7:0]    data_o,
   output logic [AW-1:0] cnt_o,
   output logic          empty_o,
   output logic          receive_o,
   output logic          ovr_o
);

   logic [7:0]    mem_q [2**AW];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          empty_q, empty_d;
   logic          rcv_q, rcv_d;
   logic          ovr_q, ovr_d;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt_q == {AW{1'b1}});
   assign do_push = push_i && !full && !clear_i;
   assign do_pop  = pop_i && !empty_q && !clear_i;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      cnt_d   = cnt_q;
      rcv_d   = 1'b0;
      ovr_d   = 1'b0;
      if (clear_i) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + 1'b1;
         if (do_pop)  rptr_d = rptr_q + 1'b1;
         if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
         else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
         rcv_d = do_push;
         ovr_d = push_i && full;
      end
      empty_d = (cnt_d == '0);
   end

   always_ff @(posedge iIF_CLOCK or negedge inRESET) begin
      if (!inRESET) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         empty_q <= 1'b1;
         rcv_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         empty_q <= empty_d;
         rcv_q   <= rcv_d;
         ovr_q   <= ovr_d;
      end
   end

   always_ff @(posedge iIF_CLOCK) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

   assign data_o    = mem_q[rptr_q];
   assign cnt_o     = cnt_q;
   assign empty_o   = empty_q;
   assign receive_o = rcv_q;
   assign ovr_o     = ovr_q;

endmodule

// File: rtl/dps_uart_rx.sv
// SCI UART receiver: RXD synchroniser, 16x prescaler, frame FSM and the receive FIFO.
//  state     | meaning
//  ST_IDLE   | line idle, waiting for a 1->0 edge on the synchronised RXD
//  ST_START  | mid-start-bit check after 8 ticks; high means glitch
//  ST_DATA   | sampling 8 data bits LSB first, one per 16 ticks
//  ST_STOP   | sampling stop bit; high stores the byte, low is a framing error
//  ST_WAITHI | after a framing error, waiting for the line to return high
module dps_uart_rx
   import dps_uart_rx_pkg::*;
#(
   parameter int P_FIFO_AW = 4
) (
   input  logic                 iIF_CLOCK,
   input  logic                 inRESET,
   input  logic [3:0]           iBAUDRATE,
   input  logic                 iRX_EN,
   input  logic                 iRX_CLEAR,
   input  logic                 iRX_REQ,
   output logic                 oRX_EMPTY,
   output logic [7:0]           oRX_DATA,
   output logic [P_FIFO_AW-1:0] oRX_BUFF_CNT,
   output logic                 oRX_RECEIVE,
   output logic                 oRX_FERR,
   output logic                 oRX_OVR,
   input  logic                 iUART_RXD
);

   rx_state_e        state_q, state_d;
   logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [3:0]       tcnt_q, tcnt_d;
   logic [2:0]       bitn_q, bitn_d;
   logic [7:0]       shift_q, shift_d;
   logic             ferr_q, ferr_d;
   logic             push_req;
   logic             tick;

   assign tick = (presc_q == div_q - 1'b1);

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      tcnt_d   = tcnt_q;
      bitn_d   = bitn_q;
      shift_d  = shift_q;
      ferr_d   = 1'b0;
      push_req = 1'b0;
      presc_d  = '0;
      if (state_q inside {ST_START, ST_DATA, ST_STOP} && !tick) presc_d = presc_q + 1'b1;

      if (!iRX_EN) begin
         state_d = ST_IDLE;
         presc_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rxd_prev_q && !rxd_sync_q) begin
                  state_d = ST_START;
                  tcnt_d  = '0;
                  div_d   = baud_div(iBAUDRATE);
               end
            end
            ST_START: begin
               if (tick) begin
                  tcnt_d = tcnt_q + 4'd1;
                  if (tcnt_q == 4'd7) begin
                     tcnt_d  = '0;
                     bitn_d  = '0;
                     state_d = rxd_sync_q ? ST_IDLE : ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  tcnt_d = tcnt_q + 4'd1;
                  if (tcnt_q == 4'd15) begin
                     shift_d = {rxd_sync_q, shift_q[7:1]};
                     bitn_d  = bitn_q + 3'd1;
                     if (bitn_q == 3'd7) state_d = ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  tcnt_d = tcnt_q + 4'd1;
                  if (tcnt_q == 4'd15) begin
                     if (rxd_sync_q) begin
                        push_req = 1'b1;
                        state_d  = ST_IDLE;
                     end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAITHI;
                     end
                  end
               end
            end
            ST_WAITHI: begin
               if (rxd_sync_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge iIF_CLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state_q    <= ST_IDLE;
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         rxd_prev_q <= 1'b1;
         presc_q    <= '0;
         div_q      <= baud_div(BAUD_9600);
         tcnt_q     <= '0;
         bitn_q     <= '0;
         shift_q    <= '0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rxd_meta_q <= iUART_RXD;
         rxd_sync_q <= rxd_meta_q;
         rxd_prev_q <= rxd_sync_q;
         presc_q    <= presc_d;
         div_q      <= div_d;
         tcnt_q     <= tcnt_d;
         bitn_q     <= bitn_d;
         shift_q    <= shift_d;
         ferr_q     <= ferr_d;
      end
   end

   dps_uart_rx_fifo #(.AW(P_FIFO_AW)) u_fifo (
      .iIF_CLOCK (iIF_CLOCK),
      .inRESET   (inRESET),
      .clear_i   (iRX_CLEAR),
      .push_i    (push_req),
      .data_i    (shift_q),
      .pop_i     (iRX_REQ),
      .data_o    (oRX_DATA),
      .cnt_o     (oRX_BUFF_CNT),
      .empty_o   (oRX_EMPTY),
      .receive_o (oRX_RECEIVE),
      .ovr_o     (oRX_OVR)
   );

   assign oRX_FERR = ferr_q;

endmodule

// File: tb/tb_dps_uart_rx.sv
// Directed bench for dps_uart_rx: frames driven at 115200 baud code (27 clocks per tick).
module tb_dps_uart_rx;

   localparam int BIT  = 16 * 27;
   localparam int STOP = 238;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] baud = 4'd4;
   logic       en = 1'b1;
   logic       clear = 1'b0;
   logic       req = 1'b0;
   logic       rxd = 1'b1;
   logic       empty;
   logic [7:0] data;
   logic [3:0] cnt;
   logic       receive, ferr, ovr;

   int tests = 0;
   int fails = 0;
   int rcv_n = 0, ferr_n = 0, ovr_n = 0;
   int cnt_at_rcv = -1;

   dps_uart_rx dut (
      .iIF_CLOCK    (clk),
      .inRESET      (rst_n),
      .iBAUDRATE    (baud),
      .iRX_EN       (en),
      .iRX_CLEAR    (clear),
      .iRX_REQ      (req),
      .oRX_EMPTY    (empty),
      .oRX_DATA     (data),
      .oRX_BUFF_CNT (cnt),
      .oRX_RECEIVE  (receive),
      .oRX_FERR     (ferr),
      .oRX_OVR      (ovr),
      .iUART_RXD    (rxd)
   );

   always #10 clk = ~clk;

   // counts high cycles, so a stretched pulse shows up as an extra event
   always @(negedge clk) begin
      if (receive) begin
         rcv_n++;
         cnt_at_rcv = int'(cnt);
      end
      if (ferr) ferr_n++;
      if (ovr)  ovr_n++;
   end

   task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len);
      rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (BIT) @(negedge clk);
      end
      rxd = stop_v;
      repeat (stop_len) @(negedge clk);
   endtask

   task automatic pop();
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #5 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tests++; if (empty !== 1'b1)   begin fails++; $display("FAIL reset_empty: got %0b want 1", empty); end
      tests++; if (cnt !== 4'd0)     begin fails++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
      tests++; if (receive !== 1'b0) begin fails++; $display("FAIL reset_receive: got %0b want 0", receive); end
      tests++; if (ferr !== 1'b0)    begin fails++; $display("FAIL reset_ferr: got %0b want 0", ferr); end
      tests++; if (ovr !== 1'b0)     begin fails++; $display("FAIL reset_ovr: got %0b want 0", ovr); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_basic();
      int r0;
      r0 = rcv_n;
      send_frame(8'hA5, 1'b1, STOP);
      repeat (2) @(negedge clk);
      tests++; if (rcv_n - r0 !== 1) begin fails++; $display("FAIL basic_receive_cycles: got %0d want 1", rcv_n - r0); end
      tests++; if (cnt_at_rcv !== 1) begin fails++; $display("FAIL basic_cnt_with_pulse: got %0d want 1", cnt_at_rcv); end
      tests++; if (cnt !== 4'd1)     begin fails++; $display("FAIL basic_cnt: got %0d want 1", cnt); end
      tests++; if (empty !== 1'b0)   begin fails++; $display("FAIL basic_empty: got %0b want 0", empty); end
      tests++; if (data !== 8'hA5)   begin fails++; $display("FAIL basic_data: got %02h want a5", data); end
      pop();
      tests++; if (cnt !== 4'd0)     begin fails++; $display("FAIL basic_pop_cnt: got %0d want 0", cnt); end
      tests++; if (empty !== 1'b1)   begin fails++; $display("FAIL basic_pop_empty: got %0b want 1", empty); end
   endtask

   task automatic test_glitch();
      int r0, f0;
      r0 = rcv_n; f0 = ferr_n;
      rxd = 1'b0;
      repeat (4 * 27) @(negedge clk);
      rxd = 1'b1;
      repeat (300) @(negedge clk);
      tests++; if (rcv_n - r0 !== 0) begin fails++; $display("FAIL glitch_receive: got %0d want 0", rcv_n - r0); end
      tests++; if (ferr_n - f0 !== 0) begin fails++; $display("FAIL glitch_ferr: got %0d want 0", ferr_n - f0); end
      tests++; if (cnt !== 4'd0)      begin fails++; $display("FAIL glitch_cnt: got %0d want 0", cnt); end
   endtask

   task automatic test_ferr();
      int r0, f0;
      r0 = rcv_n; f0 = ferr_n;
      send_frame(8'h3C, 1'b0, BIT);
      tests++; if (ferr_n - f0 !== 1) begin fails++; $display("FAIL ferr_pulse: got %0d want 1", ferr_n - f0); end
      tests++; if (cnt !== 4'd0)      begin fails++; $display("FAIL ferr_cnt: got %0d want 0", cnt); end
      repeat (10 * BIT) @(negedge clk);
      rxd = 1'b1;
      repeat (BIT) @(negedge clk);
      tests++; if (ferr_n - f0 !== 1) begin fails++; $display("FAIL break_single_ferr: got %0d want 1", ferr_n - f0); end
      tests++; if (rcv_n - r0 !== 0)  begin fails++; $display("FAIL break_receive: got %0d want 0", rcv_n - r0); end
      send_frame(8'h11, 1'b1, STOP);
      repeat (2) @(negedge clk);
      tests++; if (rcv_n - r0 !== 1)  begin fails++; $display("FAIL after_break_receive: got %0d want 1", rcv_n - r0); end
      tests++; if (cnt !== 4'd1)      begin fails++; $display("FAIL after_break_cnt: got %0d want 1", cnt); end
      tests++; if (data !== 8'h11)    begin fails++; $display("FAIL after_break_data: got %02h want 11", data); end
      pop();
      tests++; if (cnt !== 4'd0)      begin fails++; $display("FAIL after_break_pop: got %0d want 0", cnt); end
   endtask

   task automatic test_overrun();
      int r0, o0;
      r0 = rcv_n; o0 = ovr_n;
      for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, STOP);
      repeat (2) @(negedge clk);
      tests++; if (rcv_n - r0 !== 15) begin fails++; $display("FAIL fill_receive: got %0d want 15", rcv_n - r0); end
      tests++; if (ovr_n - o0 !== 1)  begin fails++; $display("FAIL fill_ovr: got %0d want 1", ovr_n - o0); end
      tests++; if (cnt !== 4'd15)     begin fails++; $display("FAIL fill_cnt: got %0d want 15", cnt); end
      tests++; if (empty !== 1'b0)    begin fails++; $display("FAIL fill_empty: got %0b want 0", empty); end
      for (int i = 0; i < 12; i++) begin
         tests++;
         if (data !== 8'(i)) begin fails++; $display("FAIL fill_order[%0d]: got %02h want %02h", i, data, 8'(i)); end
         pop();
      end
      tests++; if (cnt !== 4'd3)      begin fails++; $display("FAIL drain_cnt: got %0d want 3", cnt); end
      tests++; if (data !== 8'h0C)    begin fails++; $display("FAIL drain_head: got %02h want 0c", data); end
   endtask

   // stop-bit sample lands 4106 clocks after the start edge; clear straddles it
   task automatic test_clear();
      int r0;
      r0 = rcv_n;
      rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = (i % 2 == 0) ? 1'b1 : 1'b0;
         repeat (BIT) @(negedge clk);
      end
      rxd = 1'b1;
      repeat (216) @(negedge clk);
      clear = 1'b1; req = 1'b1;
      repeat (4) @(negedge clk);
      clear = 1'b0; req = 1'b0;
      repeat (2) @(negedge clk);
      tests++; if (cnt !== 4'd0)     begin fails++; $display("FAIL clear_cnt: got %0d want 0", cnt); end
      tests++; if (empty !== 1'b1)   begin fails++; $display("FAIL clear_empty: got %0b want 1", empty); end
      tests++; if (rcv_n - r0 !== 0) begin fails++; $display("FAIL clear_receive: got %0d want 0", rcv_n - r0); end
      repeat (BIT) @(negedge clk);
   endtask

   task automatic test_enable();
      int r0, f0;
      r0 = rcv_n; f0 = ferr_n;
      rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      rxd = 1'b1; repeat (BIT) @(negedge clk);
      rxd = 1'b0; repeat (BIT) @(negedge clk);
      rxd = 1'b1; repeat (BIT / 2) @(negedge clk);
      en = 1'b0;
      repeat (8) @(negedge clk);
      en = 1'b1;
      repeat (7 * BIT) @(negedge clk);
      tests++; if (rcv_n - r0 !== 0)  begin fails++; $display("FAIL en_abort_receive: got %0d want 0", rcv_n - r0); end
      tests++; if (ferr_n - f0 !== 0) begin fails++; $display("FAIL en_abort_ferr: got %0d want 0", ferr_n - f0); end
      tests++; if (cnt !== 4'd0)      begin fails++; $display("FAIL en_abort_cnt: got %0d want 0", cnt); end
      rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) baud = 4'd0;
         rxd = ((8'h5A >> i) & 8'h01) != 8'h00;
         repeat (BIT) @(negedge clk);
      end
      rxd = 1'b1;
      repeat (STOP) @(negedge clk);
      repeat (2) @(negedge clk);
      tests++; if (rcv_n - r0 !== 1)  begin fails++; $display("FAIL baud_latch_receive: got %0d want 1", rcv_n - r0); end
      tests++; if (cnt !== 4'd1)      begin fails++; $display("FAIL baud_latch_cnt: got %0d want 1", cnt); end
      tests++; if (data !== 8'h5A)    begin fails++; $display("FAIL baud_latch_data: got %02h want 5a", data); end
      baud = 4'd4;
      pop();
      tests++; if (empty !== 1'b1)    begin fails++; $display("FAIL baud_latch_pop: got %0b want 1", empty); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_ferr();
      test_overrun();
      test_clear();
      test_enable();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
